poets_onchip_mem_stream_reader: RTL and testbench
=================================================

// Module: poets_onchip_mem_stream_reader
// PURPOSE
//  Avalon-MM read master driving the 32x8 single-port on-chip memory s1 port (fixed read latency 1).
//  On a start command, reads a run of bytes from a start address and emits them in order on an
//  8-bit Avalon-ST source with ready/valid backpressure. Sits between the memory and the
//  streaming fabric in poets_system_streaming.
// PARAMETERS
//  ADDR_W   5   memory word-address width; depth = 2**ADDR_W
//  DATA_W   8   memory/stream data width
//  LEN_W    6   length field width; holds 0..2**ADDR_W
// PORTS
//  clk           in   1       system clock
//  reset         in   1       synchronous, active-high reset
//  start         in   1       1-cycle command strobe; accepted only when busy=0
//  start_addr    in   ADDR_W  first word address
//  length        in   LEN_W   byte count, 0..32
//  busy          out  1       command in progress
//  done          out  1       1-cycle pulse after last byte accepted downstream
//  m_address     out  ADDR_W  memory address
//  m_chipselect  out  1       memory select; high on read-issue cycles
//  m_write       out  1       tied 0
//  m_clken       out  1       tied 1
//  m_readdata    in   DATA_W  memory data, valid 1 cycle after address issue
//  st_data       out  DATA_W  stream data
//  st_valid      out  1       stream valid
//  st_ready      in   1       stream ready
// BEHAVIOUR
//  Reset: busy=0, done=0, st_valid=0, m_chipselect=0, m_address=0; FIFO and counters cleared.
//  FSM IDLE -> READ on accepted start with length!=0; start with length=0 -> done pulse next cycle, stay IDLE.
//  READ: one read per cycle while (fifo_count + inflight) < 2; address increments mod 2**ADDR_W
//   (start_addr=30, length=4 reads 30,31,0,1). After last issue -> DRAIN.
//  DRAIN: wait until FIFO empty and no read in flight -> IDLE, done=1 for one cycle, busy=0 same cycle.
//  Read-return capture: m_readdata written to FIFO exactly 1 cycle after a cycle with m_chipselect=1.
//  Stream: st_valid = FIFO not empty; byte transfers on st_valid&st_ready; data stable while stalled.
//  Simultaneous push and pop on a full FIFO is legal; the credit rule guarantees no overflow.
//  Throughput: 1 byte/cycle with st_ready held high; first byte valid 2 cycles after start.
//  start while busy=1 ignored. reset mid-command: in-flight read discarded, FIFO flushed, no done.
//  m_write=0 always; the block never writes memory.
// CONFIGURATION
//  POETS_MEM_READER_PACKET_EN defined: adds outputs st_startofpacket and st_endofpacket (1 bit each),
//   asserted with the first/last byte of a command (both on the same byte when length=1).
//  Undefined: those ports do not exist; stream is plain valid/ready/data.
// STRUCTURE
//  Package poets_mem_reader_pkg: state enum {IDLE,READ,DRAIN}, ADDR_W/DATA_W/LEN_W defaults,
//   FIFO_DEPTH=2 constant.
//  Sub-module poets_st_skid_fifo: 2-entry synchronous FIFO (push, pop, data, count, sync reset).
// TESTING
//  start_addr=0, length=32, st_ready=1 -> bytes mem[0..31] in order, 32 consecutive valid cycles, one done.
//  start_addr=30, length=4 -> m_address sequence 30,31,0,1; stream mem[30],mem[31],mem[0],mem[1].
//  length=8, st_ready toggled 1/0 every cycle -> no byte lost or duplicated; st_data stable while stalled.
//  length=0 -> no m_chipselect, done pulse 1 cycle after start, busy stays 0.
//  reset asserted after 3 of 10 bytes -> st_valid=0 next cycle, no done; new command then completes fully.
//  PACKET_EN build, length=1 -> st_startofpacket and st_endofpacket both high on the single byte.

Source files
------------

// File: rtl/poets_mem_reader_pkg.sv
// Shared types and sizing constants for the on-chip memory stream reader.
// Consumed by poets_st_skid_fifo and poets_onchip_mem_stream_reader.
package poets_mem_reader_pkg;

  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_LEN_W  = 6;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/poets_st_skid_fifo.sv
// Small synchronous FIFO buffering memory read returns ahead of the stream port.
// Push into a full FIFO is only taken when a pop happens in the same cycle.
module poets_st_skid_fifo
  import poets_mem_reader_pkg::*;
#(
  parameter int WIDTH = MEM_DATA_W
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      mem_reg [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_reg;
  logic [FIFO_PTR_W-1:0] rd_ptr_reg;
  logic [FIFO_CNT_W-1:0] count_reg;
  logic                  push_ok;
  logic                  pop_ok;

  assign pop_ok  = pop && (count_reg != '0);
  assign push_ok = push && ((count_reg != FIFO_CNT_W'(FIFO_DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + FIFO_PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + FIFO_PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + FIFO_CNT_W'(1);
        2'b01:   count_reg <= count_reg - FIFO_CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: a flush clears the count, which hides stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/poets_onchip_mem_stream_reader.sv
// Avalon-MM read master streaming a run of bytes from on-chip memory onto Avalon-ST.
// Optional packet framing (startofpacket/endofpacket) enabled by POETS_MEM_READER_PACKET_EN.
module poets_onchip_mem_stream_reader
  import poets_mem_reader_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LEN_W  = MEM_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready
`ifdef POETS_MEM_READER_PACKET_EN
  ,
  output logic              st_startofpacket,
  output logic              st_endofpacket
`endif
);

`ifdef POETS_MEM_READER_PACKET_EN
  localparam int FIFO_W = DATA_W + 2;
`else
  localparam int FIFO_W = DATA_W;
`endif
  localparam int OCC_W = FIFO_CNT_W + 1;

  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     addr_reg, addr_next;
  logic [LEN_W-1:0]      remain_reg, remain_next;
  logic                  done_reg, done_next;
  logic                  inflight_reg;
  logic                  issue;
  logic                  cmd_load;
  logic                  pop;
  logic                  credit;
  logic [OCC_W-1:0]      occupancy;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_W-1:0]     fifo_din;
  logic [FIFO_W-1:0]     fifo_dout;

  assign st_valid  = (fifo_count != '0);
  assign pop       = st_valid && st_ready;
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_reg);
  // A pop this cycle frees a slot by the time the new read returns, keeping 1 byte/cycle.
  assign credit    = (occupancy < OCC_W'(FIFO_DEPTH)) || pop;

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    remain_next = remain_reg;
    done_next   = 1'b0;
    issue       = 1'b0;
    cmd_load    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_next = 1'b1;
          end else begin
            cmd_load    = 1'b1;
            state_next  = READ;
            addr_next   = start_addr;
            remain_next = length;
          end
        end
      end
      READ: begin
        if (credit) begin
          issue       = 1'b1;
          addr_next   = addr_reg + ADDR_W'(1);
          remain_next = remain_reg - LEN_W'(1);
          if (remain_reg == LEN_W'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((fifo_count == '0) && !inflight_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      remain_reg   <= '0;
      done_reg     <= 1'b0;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      remain_reg   <= remain_next;
      done_reg     <= done_next;
      inflight_reg <= issue;
    end
  end

`ifdef POETS_MEM_READER_PACKET_EN
  logic sop_pending_reg;
  logic inflight_sop_reg;
  logic inflight_eop_reg;

  // Framing flags travel with the read so they land beside the matching byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      sop_pending_reg  <= 1'b0;
      inflight_sop_reg <= 1'b0;
      inflight_eop_reg <= 1'b0;
    end else begin
      if (cmd_load) begin
        sop_pending_reg <= 1'b1;
      end else if (issue) begin
        sop_pending_reg <= 1'b0;
      end
      inflight_sop_reg <= issue && sop_pending_reg;
      inflight_eop_reg <= issue && (remain_reg == LEN_W'(1));
    end
  end

  assign fifo_din         = {inflight_sop_reg, inflight_eop_reg, m_readdata};
  assign st_startofpacket = st_valid && fifo_dout[DATA_W+1];
  assign st_endofpacket   = st_valid && fifo_dout[DATA_W];
`else
  assign fifo_din = m_readdata;
`endif

  poets_st_skid_fifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .srst  (reset),
    .push  (inflight_reg),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign st_data      = fifo_dout[DATA_W-1:0];
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign m_address    = addr_reg;
  assign m_chipselect = issue;
  assign m_write      = 1'b0;
  assign m_clken      = 1'b1;

endmodule

// File: tb/tb_poets_onchip_mem_stream_reader.sv
// Directed self-checking bench for poets_onchip_mem_stream_reader with a latency-1 memory model.
// Packet framing checks compile in when POETS_MEM_READER_PACKET_EN is defined.
module tb_poets_onchip_mem_stream_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] start_addr;
  logic [5:0] length;
  logic       busy;
  logic       done;
  logic [4:0] m_address;
  logic       m_chipselect;
  logic       m_write;
  logic       m_clken;
  logic [7:0] m_readdata;
  logic [7:0] st_data;
  logic       st_valid;
  logic       st_ready;
`ifdef POETS_MEM_READER_PACKET_EN
  logic       st_startofpacket;
  logic       st_endofpacket;
`endif

  always #5 clk = ~clk;

  logic [7:0] mem [32];
  always @(posedge clk) m_readdata <= mem[m_address];

  poets_onchip_mem_stream_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_addr   (start_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_clken      (m_clken),
    .m_readdata   (m_readdata),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_ready     (st_ready)
`ifdef POETS_MEM_READER_PACKET_EN
    ,
    .st_startofpacket (st_startofpacket),
    .st_endofpacket   (st_endofpacket)
`endif
  );

  int tests  = 0;
  int failed = 0;

  logic [7:0] got [$];
  logic [4:0] addrs [$];
  int         done_cnt = 0;
  int         run_len  = 0;
  int         max_run  = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: transfers, issued addresses, done pulses, valid runs, stall stability.
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid", st_valid, 1);
      check("stall_data", st_data, prev_data);
    end
    prev_stall = st_valid && !st_ready;
    prev_data  = st_data;
    if (st_valid === 1'b1 && st_ready === 1'b1) got.push_back(st_data);
    if (m_chipselect === 1'b1) addrs.push_back(m_address);
    if (done === 1'b1) done_cnt++;
    if (st_valid === 1'b1) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    addrs.delete();
    done_cnt = 0;
    run_len  = 0;
    max_run  = 0;
  endtask

  task automatic start_cmd(input logic [4:0] a, input logic [5:0] l);
    start_addr = a;
    length     = l;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    for (int i = 0; i < budget; i++) begin
      if (toggle) st_ready = ~st_ready;
      step();
      if (done_cnt != 0) break;
    end
    check("done_seen", (done_cnt != 0), 1);
  endtask

  task automatic check_bytes(input logic [4:0] a, input int l);
    logic [4:0] idx;
    check("byte_count", got.size(), l);
    for (int k = 0; k < l && k < got.size(); k++) begin
      idx = a + 5'(k);
      check($sformatf("byte%0d", k), got[k], mem[idx]);
    end
  endtask

  initial begin
    logic [4:0] exp_addr [4];
    exp_addr[0] = 5'd30;
    exp_addr[1] = 5'd31;
    exp_addr[2] = 5'd0;
    exp_addr[3] = 5'd1;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37 + 5);

    reset = 1'b1; start = 1'b0; start_addr = '0; length = '0; st_ready = 1'b1;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", st_valid, 0);
    check("rst_cs", m_chipselect, 0);
    check("rst_addr", m_address, 0);
    check("rst_write", m_write, 0);
    check("rst_clken", m_clken, 1);
    reset = 1'b0;
    step();

    // Full-memory run with ready held high.
    clear_mon();
    start_cmd(5'd0, 6'd32);
    check("a_busy", busy, 1);
    check("a_cs", m_chipselect, 1);
    check("a_addr0", m_address, 0);
    check("a_valid_c0", st_valid, 0);
    step();
    check("a_valid_c1", st_valid, 0);
    step();
    check("a_valid_c2", st_valid, 1);
    check("a_first", st_data, mem[0]);
    wait_done(100, 1'b0);
    repeat (3) step();
    check("a_done_cnt", done_cnt, 1);
    check("a_run", max_run, 32);
    check("a_busy_end", busy, 0);
    check_bytes(5'd0, 32);

    // Address wrap at top of memory.
    clear_mon();
    start_cmd(5'd30, 6'd4);
    wait_done(50, 1'b0);
    repeat (2) step();
    check("b_naddr", addrs.size(), 4);
    for (int k = 0; k < 4 && k < addrs.size(); k++)
      check($sformatf("b_addr%0d", k), addrs[k], exp_addr[k]);
    check_bytes(5'd30, 4);
    check("b_done_cnt", done_cnt, 1);

    // Backpressure: ready toggles every cycle.
    clear_mon();
    st_ready = 1'b0;
    start_cmd(5'd5, 6'd8);
    wait_done(200, 1'b1);
    st_ready = 1'b1;
    repeat (2) step();
    check_bytes(5'd5, 8);
    check("c_done_cnt", done_cnt, 1);

    // Zero length command.
    clear_mon();
    start_cmd(5'd3, 6'd0);
    check("d_done", done, 1);
    check("d_busy", busy, 0);
    check("d_cs", m_chipselect, 0);
    step();
    check("d_done_low", done, 0);
    repeat (3) step();
    check("d_naddr", addrs.size(), 0);
    check("d_done_cnt", done_cnt, 1);
    check("d_nbytes", got.size(), 0);

    // Reset part way through a command, then a fresh command.
    clear_mon();
    start_cmd(5'd10, 6'd10);
    for (int i = 0; i < 50; i++) begin
      if (got.size() >= 3) break;
      step();
    end
    check("e_three", (got.size() >= 3), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("e_valid", st_valid, 0);
    check("e_busy", busy, 0);
    check("e_cs", m_chipselect, 0);
    repeat (4) step();
    check("e_no_done", done_cnt, 0);
    check("e_valid_late", st_valid, 0);
    clear_mon();
    start_cmd(5'd2, 6'd5);
    wait_done(50, 1'b0);
    repeat (2) step();
    check_bytes(5'd2, 5);
    check("e_done_cnt", done_cnt, 1);

`ifdef POETS_MEM_READER_PACKET_EN
    clear_mon();
    start_cmd(5'd7, 6'd1);
    step();
    step();
    check("f_valid", st_valid, 1);
    check("f_sop", st_startofpacket, 1);
    check("f_eop", st_endofpacket, 1);
    check("f_data", st_data, mem[7]);
    wait_done(20, 1'b0);
`endif

    check("write_low", m_write, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
